// File: rtl/stripes_weight_serializer_if.sv
// Weight-vector valid/ready handshake into the Stripes serializer.
// The master drives a vector; the slave accepts it when ready.
interface stripes_weight_serializer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
);
  logic                         w_valid;
  logic                         w_ready;
  logic signed [DATA_WIDTH-1:0] w_in [VEC_LENGTH-1:0];

  modport master (
    output w_valid,
    output w_in,
    input  w_ready
  );

  modport slave (
    input  w_valid,
    input  w_in,
    output w_ready
  );
endinterface

// File: rtl/stripes_weight_serializer.sv
// Bit-serial MSB-first weight front-end for the Stripes MAC.
// One-entry shadow buffer feeds a per-lane shift register.
module stripes_weight_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  stripes_weight_serializer_if.slave w,
  output logic [VEC_LENGTH-1:0] w_bit,
  output logic                  mac_en,
  output logic                  is_msb,
  output logic                  is_msb_delayed,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH
  } state_e;

  typedef logic signed [DATA_WIDTH-1:0] vec_t [VEC_LENGTH-1:0];

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  vec_t            shadow_q, shadow_d;
  vec_t            shift_q, shift_d;
  logic            sv_q, sv_d;
  logic            rdy_q, rdy_d;
  logic [VEC_LENGTH-1:0] w_bit_q, w_bit_d;
  logic            mac_en_q, mac_en_d;
  logic            msb_q, msb_d;
  logic            msbd_q, msbd_d;
  logic            lsb_q, lsb_d;
  logic            rvp_q;
  logic            rv_q;
  logic            busy_q, busy_d;
  logic            load;
  logic            accept;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    load     = 1'b0;
    accept   = w.w_valid && rdy_q;

    unique case (state_q)
      IDLE: load = sv_q;
      SHIFT: begin
        if (cnt_q == '0) begin
          load = sv_q;
          if (!sv_q) state_d = FLUSH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FLUSH: begin
        load = sv_q;
        if (!sv_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // consume precedes capture so a same-edge accept keeps the shadow full
    if (load) begin
      shift_d = shadow_q;
      cnt_d   = CNT_TOP;
      state_d = SHIFT;
    end
    sv_d = (sv_q && !load) || accept;
    if (accept) shadow_d = w.w_in;

    for (int j = 0; j < VEC_LENGTH; j++) begin
      w_bit_d[j] = (state_d == SHIFT) ? shift_d[j][cnt_d] : 1'b0;
    end
    mac_en_d = (state_d != IDLE);
    msb_d    = (state_d == SHIFT) && (cnt_d == CNT_TOP);
    msbd_d   = msb_q && (state_d == SHIFT);
    lsb_d    = (state_d == SHIFT) && (cnt_d == '0);
    busy_d   = (state_d != IDLE) || sv_d;
    rdy_d    = !sv_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '{default: '0};
      shift_q  <= '{default: '0};
      sv_q     <= 1'b0;
      rdy_q    <= 1'b1;
      w_bit_q  <= '0;
      mac_en_q <= 1'b0;
      msb_q    <= 1'b0;
      msbd_q   <= 1'b0;
      lsb_q    <= 1'b0;
      rvp_q    <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      sv_q     <= sv_d;
      rdy_q    <= rdy_d;
      w_bit_q  <= w_bit_d;
      mac_en_q <= mac_en_d;
      msb_q    <= msb_d;
      msbd_q   <= msbd_d;
      lsb_q    <= lsb_d;
      // LSB partial sum lands in the accumulator two cycles later
      rvp_q    <= lsb_q;
      rv_q     <= rvp_q;
      busy_q   <= busy_d;
    end
  end

  assign w.w_ready      = rdy_q;
  assign w_bit          = w_bit_q;
  assign mac_en         = mac_en_q;
  assign is_msb         = msb_q;
  assign is_msb_delayed = msbd_q;
  assign result_valid   = rv_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_stripes_weight_serializer.sv
// Bench for stripes_weight_serializer: cycle schedule model plus
// a bit-serial MAC that rebuilds dot products from the serial stream.
module tb_stripes_weight_serializer;
  localparam int DW = 8;
  localparam int VL = 16;
  localparam int NC = 2048;

  typedef logic signed [DW-1:0] vec_t [VL-1:0];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stripes_weight_serializer_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) wif ();

  logic [VL-1:0] w_bit;
  logic mac_en, is_msb, is_msb_delayed, result_valid, busy;

  stripes_weight_serializer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
    .clk            (clk),
    .reset          (reset),
    .w              (wif),
    .w_bit          (w_bit),
    .mac_en         (mac_en),
    .is_msb         (is_msb),
    .is_msb_delayed (is_msb_delayed),
    .result_valid   (result_valid),
    .busy           (busy)
  );

  bit            e_en   [NC];
  bit            e_msb  [NC];
  bit            e_imd  [NC];
  bit            e_rv   [NC];
  bit            e_busy [NC];
  bit            e_rdy  [NC];
  logic [VL-1:0] e_bit  [NC];

  int cyc;
  int last_t;
  int checks;
  int failures;
  int acc;
  int ps_q;
  int act [VL];
  int dot_q [$];
  bit primed;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin
      e_en[i]   = 1'b0;
      e_msb[i]  = 1'b0;
      e_imd[i]  = 1'b0;
      e_rv[i]   = 1'b0;
      e_busy[i] = 1'b0;
      e_rdy[i]  = 1'b1;
      e_bit[i]  = '0;
    end
    last_t = -100;
    acc    = 0;
    ps_q   = 0;
    dot_q.delete();
  endtask

  // Schedule a vector accepted at the edge ending cycle a.
  task automatic accept(int a, vec_t w);
    int s, t, dot;
    s = (a < last_t) ? last_t + 1 : a + 2;
    t = s + DW - 1;
    for (int c = a + 1; c < s; c++) begin
      e_rdy[c]  = 1'b0;
      e_busy[c] = 1'b1;
    end
    for (int k = 0; k < DW; k++) begin
      e_en[s+k]   = 1'b1;
      e_busy[s+k] = 1'b1;
      e_msb[s+k]  = (k == 0);
      for (int j = 0; j < VL; j++) e_bit[s+k][j] = w[j][DW-1-k];
    end
    e_imd[s+1]  = 1'b1;
    e_en[t+1]   = 1'b1;
    e_busy[t+1] = 1'b1;
    e_rv[t+2]   = 1'b1;
    dot = 0;
    for (int j = 0; j < VL; j++) dot += act[j] * int'(w[j]);
    dot_q.push_back(dot);
    last_t = t;
  endtask

  task automatic step(bit v, vec_t w, bit rst);
    int ps, exp_dot;
    @(negedge clk);
    if (primed) begin
      chk("w_ready", 32'(wif.w_ready), 32'(e_rdy[cyc]));
      chk("w_bit", 32'(w_bit), 32'(e_bit[cyc]));
      chk("mac_en", 32'(mac_en), 32'(e_en[cyc]));
      chk("is_msb", 32'(is_msb), 32'(e_msb[cyc]));
      chk("is_msb_delayed", 32'(is_msb_delayed), 32'(e_imd[cyc]));
      chk("result_valid", 32'(result_valid), 32'(e_rv[cyc]));
      chk("busy", 32'(busy), 32'(e_busy[cyc]));
      if (result_valid === 1'b1) begin
        exp_dot = (dot_q.size() != 0) ? dot_q.pop_front() : -999999;
        chk("mac_sum", 32'(acc), 32'(exp_dot));
      end
      ps = 0;
      for (int j = 0; j < VL; j++) ps += act[j] * int'(w_bit[j]);
      if (is_msb === 1'b1) ps = -ps;
      if (mac_en === 1'b1) begin
        acc  = (is_msb_delayed === 1'b1) ? ps_q : 2 * acc + ps_q;
        ps_q = ps;
      end
    end
    reset       = rst;
    wif.w_valid = v;
    wif.w_in    = w;
    @(posedge clk);
    if (rst) begin
      clear_model();
      cyc    = 0;
      primed = 1'b1;
    end else begin
      if (v && e_rdy[cyc]) accept(cyc, w);
      cyc++;
    end
  endtask

  function automatic vec_t fill(logic signed [DW-1:0] x);
    vec_t r;
    for (int j = 0; j < VL; j++) r[j] = x;
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int j = 0; j < VL; j++) r[j] = DW'($urandom);
    return r;
  endfunction

  vec_t z, a, b, c;

  initial begin
    checks   = 0;
    failures = 0;
    primed   = 1'b0;
    cyc      = 0;
    z        = fill('0);
    wif.w_valid = 1'b0;
    wif.w_in    = z;
    for (int j = 0; j < VL; j++) act[j] = int'($urandom_range(0, 255)) - 128;
    clear_model();

    // single vector of -123 in every lane
    step(0, z, 1);
    a = fill(8'sb1000_0101);
    step(1, a, 0);
    repeat (14) step(0, z, 0);

    // streamed pair, writes ignored while the shadow is full
    step(0, z, 1);
    a = rnd_vec();
    a[0] = 8'sh7f;
    b = rnd_vec();
    b[0] = -8'sd128;
    c = rnd_vec();
    step(1, a, 0);
    step(1, c, 0);
    step(1, b, 0);
    step(1, c, 0);
    step(1, rnd_vec(), 0);
    repeat (22) step(0, z, 0);

    // reset at cnt=4 with the shadow full
    step(0, z, 1);
    step(1, rnd_vec(), 0);
    step(0, z, 0);
    step(1, rnd_vec(), 0);
    step(0, z, 0);
    step(0, z, 0);
    step(0, z, 1);
    repeat (15) step(0, z, 0);

    // second vector three cycles after the first LSB
    step(0, z, 1);
    step(1, rnd_vec(), 0);
    repeat (11) step(0, z, 0);
    step(1, rnd_vec(), 0);
    repeat (16) step(0, z, 0);

    // random traffic
    step(0, z, 1);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rnd_vec(), 0);
    end
    repeat (24) step(0, z, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
